// File: rtl/gelato_operand_collector.sv
// Operand collector: gathers up to three source registers of one warp through the
// shared register-bank port, giving writebacks priority and bypassing them into collected slots.
module gelato_operand_collector #(
    parameter int WARP_NUM   = 4,
    parameter int REG_NUM    = 32,
    parameter int THREAD_NUM = 32,
    localparam int WW = $clog2(WARP_NUM),
    localparam int RW = $clog2(REG_NUM),
    localparam int DW = THREAD_NUM * 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rdy,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [WW-1:0]   req_warp,
    input  logic [3*RW-1:0] req_rs,
    input  logic [2:0]      req_mask,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [WW-1:0]   wb_warp,
    input  logic [RW-1:0]   wb_rd,
    input  logic [DW-1:0]   wb_data,
    output logic            bank_write,
    output logic [WW-1:0]   bank_warp_num,
    output logic [RW-1:0]   bank_reg_num,
    output logic [DW-1:0]   bank_wdata,
    input  logic [DW-1:0]   bank_rdata,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [WW-1:0]   op_warp,
    output logic [3*DW-1:0] op_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [WW-1:0]   warp_q, warp_d;
    logic [3*RW-1:0] rs_q, rs_d;
    logic [2:0]      mask_q, mask_d;
    logic [2:0]      pend_q, pend_d;
    logic [3*DW-1:0] data_q, data_d;
    logic [WW-1:0]   bwarp_q;
    logic [RW-1:0]   breg_q;
    logic [DW-1:0]   bwdata_q;

    logic            wb_go_s;
    logic            rd_go_s;
    logic [1:0]      slot_s;
    logic [RW-1:0]   slot_reg_s;
    logic [2:0]      pend_clr_s;

    function automatic logic [1:0] lowest_slot(input logic [2:0] m);
        if (m[0]) begin
            return 2'd0;
        end else if (m[1]) begin
            return 2'd1;
        end else begin
            return 2'd2;
        end
    endfunction

    // Port arbitration: a writeback always wins; a read only happens in READ on a free cycle.
    always_comb begin
        wb_go_s    = rdy && !rst_n && wb_valid;
        rd_go_s    = rdy && !rst_n && !wb_valid && (state_q == S_READ);
        slot_s     = lowest_slot(pend_q);
        slot_reg_s = rs_q[RW-1:0];
        for (int i = 0; i < 3; i++) begin
            if (slot_s == 2'(i)) begin
                slot_reg_s = rs_q[i*RW +: RW];
            end else begin
                slot_reg_s = slot_reg_s;
            end
        end
        pend_clr_s = pend_q & ~(3'b001 << slot_s);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end else begin
            state_q <= state_q;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = (req_mask == 3'b000) ? S_DONE : S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (rd_go_s && (pend_clr_s == 3'b000)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                if (op_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch, operand capture and writeback bypass into already-collected slots.
    always_comb begin
        warp_d = warp_q;
        rs_d   = rs_q;
        mask_d = mask_q;
        pend_d = pend_q;
        data_d = data_q;
        if ((state_q == S_IDLE) && req_valid) begin
            warp_d = req_warp;
            rs_d   = req_rs;
            mask_d = req_mask;
            pend_d = req_mask;
            data_d = '0;
        end else if (rd_go_s) begin
            data_d[slot_s*DW +: DW] = bank_rdata;
            pend_d                  = pend_clr_s;
        end else begin
            pend_d = pend_q;
        end
        if (wb_go_s && (state_q != S_IDLE)) begin
            for (int i = 0; i < 3; i++) begin
                if (mask_q[i] && !pend_q[i] && (warp_q == wb_warp) && (rs_q[i*RW +: RW] == wb_rd)) begin
                    data_d[i*DW +: DW] = wb_data;
                end else begin
                    data_d[i*DW +: DW] = data_d[i*DW +: DW];
                end
            end
        end else begin
            data_d = data_d;
        end
    end

    // Datapath registers, including the held bank address so an idle port keeps its last value.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            warp_q   <= '0;
            rs_q     <= '0;
            mask_q   <= 3'b000;
            pend_q   <= 3'b000;
            data_q   <= '0;
            bwarp_q  <= '0;
            breg_q   <= '0;
            bwdata_q <= '0;
        end else if (rdy) begin
            warp_q   <= warp_d;
            rs_q     <= rs_d;
            mask_q   <= mask_d;
            pend_q   <= pend_d;
            data_q   <= data_d;
            bwarp_q  <= bank_warp_num;
            breg_q   <= bank_reg_num;
            bwdata_q <= bank_wdata;
        end else begin
            warp_q   <= warp_q;
            rs_q     <= rs_q;
            mask_q   <= mask_q;
            pend_q   <= pend_q;
            data_q   <= data_q;
            bwarp_q  <= bwarp_q;
            breg_q   <= breg_q;
            bwdata_q <= bwdata_q;
        end
    end

    // Outputs; the bank address is combinational because read data returns in the same cycle.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        op_valid   = (state_q == S_DONE);
        op_warp    = warp_q;
        op_data    = data_q;
        wb_ready   = wb_go_s;
        bank_write = wb_go_s;
        if (wb_go_s) begin
            bank_warp_num = wb_warp;
            bank_reg_num  = wb_rd;
            bank_wdata    = wb_data;
        end else if (rd_go_s) begin
            bank_warp_num = warp_q;
            bank_reg_num  = slot_reg_s;
            bank_wdata    = bwdata_q;
        end else begin
            bank_warp_num = bwarp_q;
            bank_reg_num  = breg_q;
            bank_wdata    = bwdata_q;
        end
    end

endmodule

// File: tb/tb_gelato_operand_collector.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a randomized
// run against a transaction-level model (operands always equal the bank's current contents).
module tb_gelato_operand_collector;

    localparam int WARP_NUM   = 4;
    localparam int REG_NUM    = 32;
    localparam int THREAD_NUM = 32;
    localparam int WW = $clog2(WARP_NUM);
    localparam int RW = $clog2(REG_NUM);
    localparam int DW = THREAD_NUM * 32;

    logic            clk = 1'b0;
    logic            rst_n, rdy, req_valid, req_ready, wb_valid, wb_ready, bank_write;
    logic            op_valid, op_ready;
    logic [WW-1:0]   req_warp, wb_warp, bank_warp_num, op_warp;
    logic [3*RW-1:0] req_rs;
    logic [2:0]      req_mask;
    logic [RW-1:0]   wb_rd, bank_reg_num;
    logic [DW-1:0]   wb_data, bank_wdata, bank_rdata;
    logic [3*DW-1:0] op_data;

    logic [DW-1:0]   mem [WARP_NUM][REG_NUM];
    int              n_chk = 0;
    int              n_fail = 0;

    gelato_operand_collector #(.WARP_NUM(WARP_NUM), .REG_NUM(REG_NUM), .THREAD_NUM(THREAD_NUM)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .req_valid(req_valid), .req_ready(req_ready), .req_warp(req_warp), .req_rs(req_rs), .req_mask(req_mask),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_warp(wb_warp), .wb_rd(wb_rd), .wb_data(wb_data),
        .bank_write(bank_write), .bank_warp_num(bank_warp_num), .bank_reg_num(bank_reg_num),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
        .op_valid(op_valid), .op_ready(op_ready), .op_warp(op_warp), .op_data(op_data)
    );

    always #5 clk = ~clk;

    assign bank_rdata = mem[bank_warp_num][bank_reg_num];

    typedef struct {
        logic [WW-1:0]   warp;
        logic [3*RW-1:0] rs;
        logic [2:0]      mask;
        int              lat;
    } vec_t;

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int i = 0; i < THREAD_NUM; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_ops(input string nm, input logic [WW-1:0] w, input logic [3*RW-1:0] rs, input logic [2:0] m);
        logic [3*DW-1:0] e;
        for (int i = 0; i < 3; i++) e[i*DW +: DW] = m[i] ? mem[w][rs[i*RW +: RW]] : '0;
        n_chk++;
        if (op_data !== e) begin
            n_fail++;
            for (int i = 0; i < 3; i++)
                if (op_data[i*DW +: DW] !== e[i*DW +: DW])
                    $display("FAIL %s slot%0d: got low %h expected low %h at %0t", nm, i,
                             op_data[i*DW +: 64], e[i*DW +: 64], $time);
        end
    endtask

    // One clock: the bank model commits a write the DUT should have granted.
    task automatic tick();
        logic          fire = rdy && wb_valid && !rst_n;
        logic [WW-1:0] w    = wb_warp;
        logic [RW-1:0] r    = wb_rd;
        logic [DW-1:0] d    = wb_data;
        @(posedge clk);
        #1;
        if (fire) mem[w][r] = d;
    endtask

    task automatic issue(input logic [WW-1:0] w, input logic [3*RW-1:0] rs, input logic [2:0] m);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("accept_wait", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_warp  = w;
        req_rs    = rs;
        req_mask  = m;
        tick();
        req_valid = 1'b0;
    endtask

    vec_t vt[5];

    initial begin
        int cyc;
        int order[$];
        int pq[$];
        logic busy;
        logic [WW-1:0] mw;
        logic [3*RW-1:0] mrs;
        logic [2:0] mm;

        for (int w = 0; w < WARP_NUM; w++)
            for (int r = 0; r < REG_NUM; r++) mem[w][r] = rnd_data();
        rst_n = 1'b1; rdy = 1'b1; req_valid = 1'b0; req_warp = '0; req_rs = '0; req_mask = 3'b000;
        wb_valid = 1'b0; wb_warp = '0; wb_rd = '0; wb_data = '0; op_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_op_valid", 64'(op_valid), 64'd0);
        chk("rst_wb_ready", 64'(wb_ready), 64'd0);
        chk("rst_bank_write", 64'(bank_write), 64'd0);
        chk("rst_bank_addr", 64'({bank_warp_num, bank_reg_num}), 64'd0);
        chk("rst_op_warp", 64'(op_warp), 64'd0);
        chk_ops("rst_op_data", '0, '0, 3'b000);

        vt[0] = '{warp: 2'd2, rs: {5'd5, 5'd3, 5'd1},   mask: 3'b111, lat: 4};
        vt[1] = '{warp: 2'd1, rs: {5'd8, 5'd6, 5'd2},   mask: 3'b000, lat: 1};
        vt[2] = '{warp: 2'd0, rs: {5'd4, 5'd4, 5'd4},   mask: 3'b101, lat: 3};
        vt[3] = '{warp: 2'd3, rs: {5'd17, 5'd0, 5'd31}, mask: 3'b010, lat: 2};
        vt[4] = '{warp: 2'd1, rs: {5'd2, 5'd9, 5'd7},   mask: 3'b110, lat: 3};
        foreach (vt[v]) begin
            order.delete();
            for (int i = 0; i < 3; i++) if (vt[v].mask[i]) order.push_back(i);
            issue(vt[v].warp, vt[v].rs, vt[v].mask);
            cyc = 1;
            while (!op_valid && cyc < 12) begin
                if (cyc - 1 < order.size()) begin
                    chk("tbl_rd_reg", 64'(bank_reg_num), 64'(vt[v].rs[order[cyc-1]*RW +: RW]));
                    chk("tbl_rd_warp", 64'(bank_warp_num), 64'(vt[v].warp));
                    chk("tbl_rd_we", 64'(bank_write), 64'd0);
                    chk("tbl_busy_req_ready", 64'(req_ready), 64'd0);
                end
                tick();
                cyc++;
            end
            chk("tbl_latency", 64'(cyc), 64'(vt[v].lat));
            chk("tbl_op_warp", 64'(op_warp), 64'(vt[v].warp));
            chk_ops("tbl_op_data", vt[v].warp, vt[v].rs, vt[v].mask);
            op_ready = 1'b1;
            tick();
            op_ready = 1'b0;
            chk("tbl_no_reaccept", 64'({req_ready, op_valid}), 64'b10);
        end

        // Writeback steals the first READ cycle.
        issue(2'd0, {5'd0, 5'd7, 5'd4}, 3'b011);
        wb_valid = 1'b1; wb_warp = 2'd3; wb_rd = 5'd9; wb_data = rnd_data();
        #1;
        chk("wbst_write", 64'({bank_write, wb_ready}), 64'b11);
        chk("wbst_addr", 64'({bank_warp_num, bank_reg_num}), 64'({2'd3, 5'd9}));
        chk("wbst_wdata", bank_wdata[63:0], wb_data[63:0]);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("wbst_r4_late", 64'({bank_write, bank_reg_num}), 64'({1'b0, 5'd4}));
        tick();
        chk("wbst_r7", 64'(bank_reg_num), 64'd7);
        tick();
        chk("wbst_op_valid_c4", 64'(op_valid), 64'd1);
        chk_ops("wbst_op_data", 2'd0, {5'd0, 5'd7, 5'd4}, 3'b011);

        // Bypass while waiting in DONE.
        wb_valid = 1'b1; wb_warp = 2'd0; wb_rd = 5'd4; wb_data = {THREAD_NUM{32'hAAAA_AAAA}};
        tick();
        wb_warp = 2'd1; wb_data = rnd_data();
        chk("byp_hit", op_data[63:0], 64'hAAAA_AAAA_AAAA_AAAA);
        tick();
        wb_valid = 1'b0;
        chk("byp_miss_warp", op_data[63:0], 64'hAAAA_AAAA_AAAA_AAAA);
        chk_ops("byp_op_data", 2'd0, {5'd0, 5'd7, 5'd4}, 3'b011);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;

        // Freeze for two cycles in the middle of a collection.
        issue(2'd1, {5'd10, 5'd6, 5'd2}, 3'b111);
        chk("frz_r2", 64'(bank_reg_num), 64'd2);
        tick();
        rdy = 1'b0; wb_valid = 1'b1; wb_warp = 2'd1; wb_rd = 5'd6; wb_data = rnd_data();
        #1;
        chk("frz_no_access", 64'({bank_write, wb_ready}), 64'b00);
        tick();
        chk("frz_no_access2", 64'({bank_write, wb_ready, op_valid}), 64'b000);
        tick();
        rdy = 1'b1; wb_valid = 1'b0;
        #1;
        chk("frz_resume_r6", 64'({bank_reg_num, op_valid}), 64'({5'd6, 1'b0}));
        tick();
        chk("frz_r10", 64'(bank_reg_num), 64'd10);
        tick();
        chk("frz_op_valid", 64'(op_valid), 64'd1);
        chk_ops("frz_op_data", 2'd1, {5'd10, 5'd6, 5'd2}, 3'b111);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;

        // Reset after one operand has been collected.
        issue(2'd2, {5'd5, 5'd3, 5'd1}, 3'b111);
        tick();
        rst_n = 1'b1; wb_valid = 1'b1; wb_warp = 2'd2; wb_rd = 5'd1; wb_data = rnd_data();
        #1;
        chk("rstmid_no_write", 64'(bank_write), 64'd0);
        tick();
        rst_n = 1'b0; wb_valid = 1'b0;
        #1;
        chk("rstmid_state", 64'({req_ready, op_valid, op_warp}), 64'({1'b1, 1'b0, 2'd0}));
        chk_ops("rstmid_op_data", '0, '0, 3'b000);

        // Randomized run against the transaction-level model.
        busy = 1'b0; mw = '0; mrs = '0; mm = 3'b000;
        for (int c = 0; c < 1500; c++) begin
            rdy       = ($urandom_range(9) != 0);
            wb_valid  = ($urandom_range(3) == 0);
            wb_warp   = WW'($urandom_range(WARP_NUM - 1));
            wb_rd     = RW'($urandom_range(3));
            wb_data   = rnd_data();
            req_valid = $urandom_range(1) == 1;
            req_warp  = WW'($urandom_range(WARP_NUM - 1));
            req_rs    = {RW'($urandom_range(3)), RW'($urandom_range(3)), RW'($urandom_range(3))};
            req_mask  = 3'($urandom_range(7));
            op_ready  = $urandom_range(1) == 1;
            #1;
            chk("rnd_wb_ready", 64'({wb_ready, bank_write}), 64'({2{rdy && wb_valid}}));
            if (rdy && wb_valid)
                chk("rnd_wb_addr", 64'({bank_warp_num, bank_reg_num}), 64'({wb_warp, wb_rd}));
            chk("rnd_req_ready", 64'(req_ready), 64'(!busy));
            chk("rnd_op_valid", 64'(op_valid), 64'(busy && pq.size() == 0));
            if (busy && pq.size() == 0 && op_valid) begin
                chk("rnd_op_warp", 64'(op_warp), 64'(mw));
                chk_ops("rnd_op_data", mw, mrs, mm);
            end
            if (busy && pq.size() > 0 && rdy && !wb_valid)
                chk("rnd_rd_addr", 64'({bank_warp_num, bank_reg_num}), 64'({mw, mrs[pq[0]*RW +: RW]}));
            if (rdy) begin
                if (!busy && req_valid) begin
                    busy = 1'b1; mw = req_warp; mrs = req_rs; mm = req_mask;
                    pq.delete();
                    for (int i = 0; i < 3; i++) if (req_mask[i]) pq.push_back(i);
                end else if (busy && pq.size() > 0) begin
                    if (!wb_valid) void'(pq.pop_front());
                end else if (busy && op_ready) begin
                    busy = 1'b0;
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
